md_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller that owns the HI/LO registers for the 5-stage pipeline.
- Driven from the E stage, one operation per `start` pulse.
- Sequences a fixed-latency busy window and commits HI/LO at its end.
- `busy` is exported to the stall unit; a D-stage md-class instruction stalls while `start | busy`.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_arith.sv | 70 +++++++
 rtl/md_ctrl.sv | 114 +++++++++++
 tb/tb_md_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller: operation codes,
// FSM state encoding and default busy-window lengths.
package md_pkg;

    localparam int MD_OP_W         = 3;
    localparam int MD_MULT_CYCLES  = 5;
    localparam int MD_DIV_CYCLES   = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the given
// operation and flags a zero divisor so the controller can skip the commit.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [63:0]        result,
    output logic               div_by_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed divide works on magnitudes and fixes signs afterwards; this also
    // makes 0x80000000 / -1 fall out naturally as quotient 0x80000000.
    assign a_neg = a[31];
    assign b_neg = b[31];
    assign a_mag = a_neg ? (32'd0 - a) : a;
    assign b_mag = b_neg ? (32'd0 - b) : b;

    // Select the arithmetic result for the requested operation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        result      = 64'd0;
        div_by_zero = 1'b0;
        quo         = 32'd0;
        rem         = 32'd0;
        case (op)
            MD_MULT: begin
                // Low 64 bits of a product of sign-extended operands equal the
                // signed 32x32 product.
                result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            end
            MD_MULTU: begin
                result = {32'd0, a} * {32'd0, b};
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    quo = a_mag / b_mag;
                    rem = a_mag % b_mag;
                    if (a_neg ^ b_neg) quo = 32'd0 - quo;
                    if (a_neg)         rem = 32'd0 - rem;
                    result = {rem, quo};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div_by_zero = 1'b1;
                end else begin
                    quo    = a / b;
                    rem    = a % b;
                    result = {rem, quo};
                end
            end
            default: begin
                result = 64'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller owning HI/LO. A start in IDLE either writes
// HI/LO directly (mthi/mtlo) or latches an arithmetic result and holds busy
// for a fixed number of cycles before committing it.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_dz_q, pend_dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] ar_result;
    logic        ar_dz;

    md_arith u_arith (
        .op          (md_op),
        .a           (A),
        .b           (B),
        .result      (ar_result),
        .div_by_zero (ar_dz)
    );

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 64'd0;
            pend_dz_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state logic: accept work in IDLE, count down and commit in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_d    = ar_result;
                            pend_dz_d = 1'b0;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_d    = ar_result;
                            pend_dz_d = ar_dz;
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // A start here is a protocol violation and is simply ignored.
                if (cnt_q == CW'(1)) begin
                    if (!pend_dz_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl. Busy-window operations push their expected
// busy length and HI/LO into a scoreboard queue; a negedge monitor pops and
// compares whenever busy falls. Register moves and reset are checked inline.
module tb_md_ctrl;
    import md_pkg::*;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one start cycle; caller is positioned 1 time unit after a rising
    // edge and ends up 1 unit after the edge that sampled the start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.name = name; e.cycles = cyc; e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        issue(op, a, b);
        wait_idle();
    endtask

    // Monitor: count busy cycles and compare HI/LO when busy drops.
    initial begin
        int   busy_cnt  = 0;
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_completion: got busy fall with HI=0x%0h LO=0x%0h expected none", HI, LO);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_cycles"}, 64'(busy_cnt), 64'(e.cycles));
                        check({e.name, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
                        check({e.name, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
                    end
                    busy_cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mult",  MD_MULT,  32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  MD_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

        issue(MD_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", {32'd0, HI}, 64'h1234);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        issue(MD_MTLO, 32'h5678, 32'd0);
        check("mtlo_lo", {32'd0, LO}, 64'h5678);
        check("mtlo_hi_kept", {32'd0, HI}, 64'h1234);

        run_op("div0",  MD_DIV,  32'd5, 32'd0, 10, 32'h1234, 32'h5678);
        run_op("divu0", MD_DIVU, 32'hDEAD, 32'd0, 10, 32'h1234, 32'h5678);

        issue(3'd7, 32'hFFFF, 32'hFFFF);
        check("undef_busy", {63'd0, busy}, 64'd0);
        check("undef_hi", {32'd0, HI}, 64'h1234);
        check("undef_lo", {32'd0, LO}, 64'h5678);

        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        run_op("mult_big", MD_MULT, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'd0);

        // MULT at t, illegal DIV at t+2, back-to-back MULTU when busy drops.
        begin
            exp_t e;
            e.name = "mult_ign"; e.cycles = 5; e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFF4;
            sb_q.push_back(e);
            issue(MD_MULT, 32'd3, 32'hFFFFFFFC);
            @(posedge clk); #1;
            issue(MD_DIV, 32'd100, 32'd7);
            check("ign_busy", {63'd0, busy}, 64'd1);
            wait_idle();
            run_op("b2b_multu", MD_MULTU, 32'd5, 32'd6, 5, 32'd0, 32'h1E);
        end

        // Asynchronous reset in the middle of a divide.
        issue(MD_DIV, 32'd9, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("async_busy", {63'd0, busy}, 64'd0);
        check("async_hi", {32'd0, HI}, 64'd0);
        check("async_lo", {32'd0, LO}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(MD_MTLO, 32'hABCD, 32'd0);
        check("post_mtlo_lo", {32'd0, LO}, 64'hABCD);
        check("post_mtlo_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("post_mtlo_busy2", {63'd0, busy}, 64'd0);
        check("post_mtlo_hi", {32'd0, HI}, 64'd0);

        @(posedge clk); #1;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
